// File: rtl/decode.sv
// Purpose: MIPS ID stage. Decodes controls, reads the 32x32 register file and sign-extends the immediate into the ID/EX latch.
// Latency: one cycle from IF/ID to ID/EX. A write-back is visible to the same-cycle read through the bypass.
// Backpressure: id_stall (combinational load-use) makes fetch hold, and a bubble is loaded. ex_mem_pc_src flushes ID/EX.
module decode #(
  parameter logic [5:0] NOP_OPCODE    = 6'b100000,
  parameter bit         RESET_ZERO_RF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_instr,
  input  logic [31:0] if_id_npc,
  input  logic        ex_mem_pc_src,
  input  logic        mem_wb_reg_write,
  input  logic [4:0]  mem_wb_write_reg,
  input  logic [31:0] mem_wb_write_data,
  output logic [1:0]  id_ex_wb,
  output logic [2:0]  id_ex_m,
  output logic [3:0]  id_ex_ex,
  output logic [31:0] id_ex_npc,
  output logic [31:0] id_ex_readdat1,
  output logic [31:0] id_ex_readdat2,
  output logic [31:0] id_ex_sign_ext,
  output logic [4:0]  id_ex_instr_2016,
  output logic [4:0]  id_ex_instr_1511,
  output logic        id_stall
);

  // Control bundle. The field order matches the id_ex_wb/m/ex port packing.
  typedef struct packed {
    logic [1:0] wb;   // {reg_write, mem_to_reg}
    logic [2:0] m;    // {branch, mem_read, mem_write}
    logic [3:0] ex;   // {reg_dst, alu_op[1:0], alu_src}
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] sign_ext;
  logic        wr_en;
  logic [31:0] rd_dat1;
  logic [31:0] rd_dat2;
  ctrl_t       ctrl;

  logic [31:0] rf [32];

  assign opcode   = if_id_instr[31:26];
  assign rs       = if_id_instr[25:21];
  assign rt       = if_id_instr[20:16];
  assign rd       = if_id_instr[15:11];
  assign sign_ext = {{16{if_id_instr[15]}}, if_id_instr[15:0]};

  // r0 is hardwired, so writes to it are dropped here and never reach the array.
  assign wr_en = mem_wb_reg_write && (mem_wb_write_reg != 5'd0);

  generate
    if (RESET_ZERO_RF) begin : g_rf_rst
      // Register file write port. Reset clears all entries and suppresses a write on the reset edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < 32; i++) begin
            rf[i] <= '0;
          end
        end else if (wr_en) begin
          rf[mem_wb_write_reg] <= mem_wb_write_data;
        end
      end
    end else begin : g_rf_norst
      // Register file write port without reset clearing. Writes are still blocked while rst is high.
      always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
          rf[mem_wb_write_reg] <= mem_wb_write_data;
        end
      end
    end
  endgenerate

  // Asynchronous read ports. r0 reads as zero, and a same-cycle write-back is forwarded.
  always_comb begin
    rd_dat1 = '0;
    rd_dat2 = '0;
    if (rs != 5'd0) begin
      rd_dat1 = (wr_en && (mem_wb_write_reg == rs)) ? mem_wb_write_data : rf[rs];
    end
    if (rt != 5'd0) begin
      rd_dat2 = (wr_en && (mem_wb_write_reg == rt)) ? mem_wb_write_data : rf[rt];
    end
  end

  // Control decode. The bubble opcode is tested first so an override can never alias a real opcode.
  always_comb begin
    ctrl = '0;
    if (opcode != NOP_OPCODE) begin
      case (opcode)
        OP_RTYPE: ctrl = '{wb: 2'b10, m: 3'b000, ex: 4'b1100};
        OP_LW:    ctrl = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
        OP_SW:    ctrl = '{wb: 2'b00, m: 3'b001, ex: 4'b0001};
        OP_BEQ:   ctrl = '{wb: 2'b00, m: 3'b100, ex: 4'b0010};
        default:  ctrl = '0;
      endcase
    end
  end

  // Load-use hazard: the load in ID/EX writes a register that this instruction reads.
  // id_stall stays low during reset because the latch is cleared asynchronously.
  assign id_stall = id_ex_m[1] && (id_ex_instr_2016 != 5'd0) &&
                    ((id_ex_instr_2016 == rs) || (id_ex_instr_2016 == rt));

  // ID/EX latch. Priority is reset, then flush or stall (bubble, every field zero), then capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_wb         <= '0;
      id_ex_m          <= '0;
      id_ex_ex         <= '0;
      id_ex_npc        <= '0;
      id_ex_readdat1   <= '0;
      id_ex_readdat2   <= '0;
      id_ex_sign_ext   <= '0;
      id_ex_instr_2016 <= '0;
      id_ex_instr_1511 <= '0;
    end else if (ex_mem_pc_src || id_stall) begin
      id_ex_wb         <= '0;
      id_ex_m          <= '0;
      id_ex_ex         <= '0;
      id_ex_npc        <= '0;
      id_ex_readdat1   <= '0;
      id_ex_readdat2   <= '0;
      id_ex_sign_ext   <= '0;
      id_ex_instr_2016 <= '0;
      id_ex_instr_1511 <= '0;
    end else begin
      id_ex_wb         <= ctrl.wb;
      id_ex_m          <= ctrl.m;
      id_ex_ex         <= ctrl.ex;
      id_ex_npc        <= if_id_npc;
      id_ex_readdat1   <= rd_dat1;
      id_ex_readdat2   <= rd_dat2;
      id_ex_sign_ext   <= sign_ext;
      id_ex_instr_2016 <= rt;
      id_ex_instr_1511 <= rd;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Purpose: directed and randomized bench for decode, with a register-array and latch reference model.
// Latency: inputs are driven at negedge, id_stall is sampled before posedge, and ID/EX is sampled 1ns after posedge.
// Backpressure: the bench acts as fetch and re-presents the same instruction while a stall is predicted.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_id_instr = '0;
  logic [31:0] if_id_npc = '0;
  logic        ex_mem_pc_src = 1'b0;
  logic        mem_wb_reg_write = 1'b0;
  logic [4:0]  mem_wb_write_reg = '0;
  logic [31:0] mem_wb_write_data = '0;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_npc;
  logic [31:0] id_ex_readdat1;
  logic [31:0] id_ex_readdat2;
  logic [31:0] id_ex_sign_ext;
  logic [4:0]  id_ex_instr_2016;
  logic [4:0]  id_ex_instr_1511;
  logic        id_stall;

  decode dut (
    .clk(clk), .rst(rst),
    .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
    .ex_mem_pc_src(ex_mem_pc_src),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_write_reg(mem_wb_write_reg),
    .mem_wb_write_data(mem_wb_write_data),
    .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m), .id_ex_ex(id_ex_ex),
    .id_ex_npc(id_ex_npc), .id_ex_readdat1(id_ex_readdat1), .id_ex_readdat2(id_ex_readdat2),
    .id_ex_sign_ext(id_ex_sign_ext), .id_ex_instr_2016(id_ex_instr_2016),
    .id_ex_instr_1511(id_ex_instr_1511), .id_stall(id_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: the architectural register contents and the expected ID/EX contents.
  logic [31:0] mrf [32];
  logic [8:0]  e_ctrl;
  logic [31:0] e_npc, e_rd1, e_rd2, e_se;
  logic [4:0]  e_rt, e_rd;
  logic        obs_stall;
  logic        last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Decode table as a lookup from opcode to {wb, m, ex}.
  function automatic logic [8:0] ctrl_model(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2b:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b0;
    endcase
  endfunction

  // Architectural read value: r0 is zero, and an in-flight write-back to the same register wins.
  function automatic logic [31:0] read_model(input logic [4:0] a, input logic we,
                                             input logic [4:0] wr, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && wr == a) return wd;
    return mrf[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    e_ctrl = '0; e_npc = '0; e_rd1 = '0; e_rd2 = '0; e_se = '0; e_rt = '0; e_rd = '0;
    last_stall = 1'b0;
  endtask

  task automatic check_latch(input string pfx);
    check({pfx, "_wb"},  {30'b0, id_ex_wb}, {30'b0, e_ctrl[8:7]});
    check({pfx, "_m"},   {29'b0, id_ex_m},  {29'b0, e_ctrl[6:4]});
    check({pfx, "_ex"},  {28'b0, id_ex_ex}, {28'b0, e_ctrl[3:0]});
    check({pfx, "_npc"}, id_ex_npc, e_npc);
    check({pfx, "_rd1"}, id_ex_readdat1, e_rd1);
    check({pfx, "_rd2"}, id_ex_readdat2, e_rd2);
    check({pfx, "_se"},  id_ex_sign_ext, e_se);
    check({pfx, "_rt"},  {27'b0, id_ex_instr_2016}, {27'b0, e_rt});
    check({pfx, "_rdf"}, {27'b0, id_ex_instr_1511}, {27'b0, e_rd});
  endtask

  // One pipeline cycle. It is entered at a negedge and returns at the following negedge.
  task automatic cycle(input logic [31:0] ins, input logic [31:0] npc, input logic flush,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd);
    logic [8:0]  c;
    logic [31:0] r1, r2;
    logic        st;
    if_id_instr = ins; if_id_npc = npc; ex_mem_pc_src = flush;
    mem_wb_reg_write = we; mem_wb_write_reg = wr; mem_wb_write_data = wd;
    #1;
    st = e_ctrl[5] && (e_rt != 0) && (e_rt == ins[25:21] || e_rt == ins[20:16]);
    obs_stall = id_stall;
    check("stall", {31'b0, id_stall}, {31'b0, st});
    r1 = read_model(ins[25:21], we, wr, wd);
    r2 = read_model(ins[20:16], we, wr, wd);
    c  = ctrl_model(ins[31:26]);
    @(posedge clk);
    if (flush || st) begin
      e_ctrl = '0; e_npc = '0; e_rd1 = '0; e_rd2 = '0; e_se = '0; e_rt = '0; e_rd = '0;
    end else begin
      e_ctrl = c; e_npc = npc; e_rd1 = r1; e_rd2 = r2;
      e_se = {{16{ins[15]}}, ins[15:0]}; e_rt = ins[20:16]; e_rd = ins[15:11];
    end
    if (we && wr != 0) mrf[wr] = wd;
    last_stall = st;
    #1;
    check_latch("idex");
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges. It is entered at a negedge and returns at a later negedge.
  task automatic do_reset(input logic try_write);
    #2 rst = 1'b1;
    ex_mem_pc_src = 1'b0;
    mem_wb_reg_write = try_write; mem_wb_write_reg = 5'd5; mem_wb_write_data = 32'h1234_5678;
    #1;
    clear_model();
    check_latch("arst");
    check("arst_stall", {31'b0, id_stall}, 32'h0);
    @(posedge clk);
    #1;
    check_latch("rst_edge");
    @(negedge clk);
    rst = 1'b0;
    mem_wb_reg_write = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  op;
    logic [31:0] ins;
    case ($urandom_range(0, 5))
      0: op = 6'h00;
      1: op = 6'h23;
      2: op = 6'h2b;
      3: op = 6'h04;
      4: op = 6'h20;
      default: op = 6'($urandom);
    endcase
    ins = $urandom;
    ins[31:26] = op;
    // A narrow register range makes load-use and bypass collisions common.
    if ($urandom_range(0, 3) != 0) begin
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
    end
    return ins;
  endfunction

  initial begin
    logic [31:0] cur;
    clear_model();
    #1 rst = 1'b1;
    #1;
    check_latch("por");
    check("por_stall", {31'b0, id_stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset with a write-back pending on the reset edge, then read every register pair.
    do_reset(1'b1);
    for (int i = 0; i < 32; i++) begin
      cur = {6'h00, 5'(i), 5'(31 - i), 16'h0820};
      cycle(cur, 32'h100 + 32'(i), 0, 0, 0, 0);
    end

    // Write-back followed by an add, then a same-cycle bypass.
    cycle(32'h8000_0000, 32'h4, 0, 1, 5'd1, 32'h5);
    cycle(32'h8000_0000, 32'h8, 0, 1, 5'd2, 32'h3);
    cycle(32'h0022_0820, 32'hC, 0, 0, 0, 0);
    check("add_rd1", id_ex_readdat1, 32'h5);
    check("add_rd2", id_ex_readdat2, 32'h3);
    check("add_wb", {30'b0, id_ex_wb}, 32'h2);
    check("add_ex", {28'b0, id_ex_ex}, 32'hC);
    check("add_rd", {27'b0, id_ex_instr_1511}, 32'h1);
    cycle(32'h0022_0820, 32'h10, 0, 1, 5'd2, 32'h7);
    check("bypass_rd2", id_ex_readdat2, 32'h7);

    // Load followed by a dependent add: one stall cycle, then capture.
    cycle(32'h8C01_FFFC, 32'h14, 0, 0, 0, 0);
    check("lw_se", id_ex_sign_ext, 32'hFFFF_FFFC);
    check("lw_m", {29'b0, id_ex_m}, 32'h2);
    cycle(32'h0022_0820, 32'h18, 0, 0, 0, 0);
    check("lu_stall_on", {31'b0, obs_stall}, 32'h1);
    check("lu_bubble", {23'b0, id_ex_wb, id_ex_m, id_ex_ex}, 32'h0);
    cycle(32'h0022_0820, 32'h18, 0, 0, 0, 0);
    check("lu_stall_off", {31'b0, obs_stall}, 32'h0);
    check("lu_resume_wb", {30'b0, id_ex_wb}, 32'h2);

    // r0 ignores writes, both registered and bypassed.
    cycle(32'h8000_0000, 32'h1C, 0, 1, 5'd0, 32'hDEAD_BEEF);
    cycle(32'h0000_0820, 32'h20, 0, 1, 5'd0, 32'hDEAD_BEEF);
    check("r0_rd1", id_ex_readdat1, 32'h0);
    check("r0_rd2", id_ex_readdat2, 32'h0);

    // Bubble opcode and flush.
    cycle(32'h8000_0000, 32'h24, 0, 0, 0, 0);
    check("nop_ctrl", {23'b0, id_ex_wb, id_ex_m, id_ex_ex}, 32'h0);
    cycle(32'h0022_0820, 32'h28, 1, 0, 0, 0);
    check("flush_ctrl", {23'b0, id_ex_wb, id_ex_m, id_ex_ex}, 32'h0);

    // Asynchronous reset while ID/EX holds a load.
    cycle(32'h8C01_FFFC, 32'h2C, 0, 0, 0, 0);
    check("pre_rst_m", {29'b0, id_ex_m}, 32'h2);
    do_reset(1'b0);

    // Randomized run. The bench acts as fetch and holds the instruction while a stall is predicted.
    cur = rand_instr();
    for (int n = 0; n < 600; n++) begin
      if (!last_stall) cur = rand_instr();
      if (n == 300) do_reset($urandom_range(0, 1) == 1);
      cycle(cur, $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 31) < 24 ? $urandom_range(0, 3) : $urandom_range(0, 31)),
            $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of fetch.
- Consumes the IF/ID latch outputs and holds the 32x32 register file, written by the write-back stage.
- Decodes control signals, sign-extends the immediate, detects load-use hazards and registers all results into the ID/EX latch.

Parameters:
- NOP_OPCODE, 6'b100000, opcode treated as pipeline bubble; all controls zero.
- RESET_ZERO_RF, 1, when 1 the async reset clears all 32 registers; when 0 only the ID/EX latch resets.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- if_id_instr  in  32  instruction from IF/ID latch
- if_id_npc  in  32  PC value from IF/ID latch
- ex_mem_pc_src  in  1  taken branch in EX/MEM; flush the ID/EX latch
- mem_wb_reg_write  in  1  write-back enable
- mem_wb_write_reg  in  5  write-back destination
- mem_wb_write_data  in  32  write-back data
- id_ex_wb  out  2  {reg_write, mem_to_reg}
- id_ex_m  out  3  {branch, mem_read, mem_write}
- id_ex_ex  out  4  {reg_dst, alu_op[1:0], alu_src}
- id_ex_npc  out  32  passed-through PC
- id_ex_readdat1  out  32  rs value
- id_ex_readdat2  out  32  rt value
- id_ex_sign_ext  out  32  sign-extended instr[15:0]
- id_ex_instr_2016  out  5  rt field
- id_ex_instr_1511  out  5  rd field
- id_stall  out  1  combinational load-use hazard; fetch must hold PC and IF/ID while high

Behaviour:
- Reset (async, rst high):
  - All id_ex_* outputs go to 0.
  - Register file clears when RESET_ZERO_RF=1.
  - id_stall is 0 while reset is held.
- Decode table, by opcode instr[31:26]:
  - R-type 000000 -> wb=10, m=000, ex=1100.
  - lw 100011 -> wb=11, m=010, ex=0001.
  - sw 101011 -> wb=00, m=001, ex=0001.
  - beq 000100 -> wb=00, m=100, ex=0010.
  - NOP_OPCODE and every other opcode -> all controls 0.
  - ex field is {reg_dst, alu_op, alu_src}.
- Register file:
  - 32x32, two asynchronous read ports addressed by instr[25:21] and instr[20:16].
  - One synchronous write on posedge clk when mem_wb_reg_write=1 and mem_wb_write_reg!=0.
  - Register 0 always reads 0; writes to it are ignored.
  - Write-through bypass: when a write is enabled to a nonzero register that matches a read address in the same cycle, that read port returns mem_wb_write_data combinationally.
- Sign extension: id_ex_sign_ext = {{16{instr[15]}}, instr[15:0]}, computed for every opcode.
- Hazard detection: id_stall = id_ex_m[1] & (id_ex_instr_2016 != 0) & (id_ex_instr_2016 == instr[25:21] | id_ex_instr_2016 == instr[20:16]).
- ID/EX latch, on posedge clk, in priority order:
  - rst forces all outputs to 0.
  - ex_mem_pc_src=1: load a bubble (wb, m, ex = 0; data fields don't-care, loaded as 0).
  - id_stall=1: load a bubble with the same treatment as a flush.
  - Otherwise: capture the decoded values, read data, sign_ext, rt, rd and if_id_npc.
- Latency: one cycle from IF/ID to ID/EX. Register write to read visibility is 0 cycles via the bypass.
- Simultaneous events:
  - Flush and stall together -> single bubble; id_stall stays high until the offending load leaves ID/EX.
  - Write-back to the register being read during a stall -> the bypass value is taken on the following unstalled capture.
- Reset mid-operation: pending decode is lost and no register file write occurs on the reset edge.

Test Plan:
- Reset, then read every register -> all 0; all id_ex_* outputs 0; id_stall 0.
- Write r1=0x00000005 via write-back, then decode 0x00220820 (add r1,r1,r2) with r2=0x00000003 -> next edge: readdat1=5, readdat2=3, wb=10, ex=1100, rd=1; same-cycle write of r2=7 while decoding -> readdat2=7.
- Decode lw 0x8C01FFFC -> sign_ext=0xFFFFFFFC, wb=11, m=010, ex=0001, rt=1; the following add using r1 raises id_stall for exactly one cycle and ID/EX shows a bubble.
- Write to r0 with data 0xDEADBEEF, then read r0 -> 0.
- Decode 0x80000000 -> all controls 0; assert ex_mem_pc_src during a valid add -> ID/EX controls 0 on that edge.
- Assert rst asynchronously between clock edges while ID/EX holds lw controls -> outputs clear immediately, before the next posedge.
